// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: issues decoded ops to a 2-cycle ALU or a variable-latency FPU
// and queues results in an OUT_DEPTH-entry FIFO. Optional FPU watchdog: EXEC_FPU_WATCHDOG_EN.
module exec_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 64,
  parameter int unsigned OUT_DEPTH   = 2,
  parameter int unsigned FPU_TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,      // synchronous, active-low
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_in_fp,
  input  logic                  i_in_mem,
  input  logic [3:0]            i_in_aluop,
  input  logic [DATA_WIDTH-1:0] i_in_op1,
  input  logic [DATA_WIDTH-1:0] i_in_op2,
  input  logic [TAG_WIDTH-1:0]  i_in_tag,
  output logic [3:0]            o_alu_op,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_fpu_start,
  output logic [3:0]            o_fpu_op,
  output logic [DATA_WIDTH-1:0] o_fpu_a,
  output logic [DATA_WIDTH-1:0] o_fpu_b,
  input  logic [DATA_WIDTH-1:0] i_fpu_result,
  input  logic                  i_fpu_valid,
  output logic                  o_fpu_abort,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_result,
  output logic [TAG_WIDTH-1:0]  o_out_tag,
  output logic                  o_out_err
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0 || FPU_TIMEOUT == 0) begin : g_bad_cfg
    $error("exec_sequencer: OUT_DEPTH must be a power of two >= 2 and FPU_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_INT, S_FP} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_mem_res [OUT_DEPTH];
  logic [TAG_WIDTH-1:0]  r_mem_tag [OUT_DEPTH];

  logic [CNT_W-1:0]      w_occupancy;
  logic                  w_accept;
  logic                  w_int_path;
  logic                  w_fp_done;
  logic                  w_fp_tmo;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_res;

`ifdef EXEC_FPU_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(FPU_TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_mem_err [OUT_DEPTH];

  assign w_fp_tmo  = (r_state == S_FP) && !i_fpu_valid && (r_wd_cnt == WD_W'(FPU_TIMEOUT));
  assign o_out_err = o_out_valid && r_mem_err[r_rd_ptr];
`else
  assign w_fp_tmo  = 1'b0;
  assign o_out_err = 1'b0;
`endif

  // The op in flight reserves a FIFO slot, so a push can never hit a full FIFO.
  assign w_occupancy = r_count + CNT_W'(r_state != S_IDLE);
  assign o_in_ready  = i_reset && !i_flush && (r_state != S_FP) &&
                       (w_occupancy < CNT_W'(OUT_DEPTH));
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_int_path  = !i_in_fp || i_in_mem;

  assign w_fp_done  = (r_state == S_FP) && i_fpu_valid;
  assign w_push     = !i_flush && ((r_state == S_INT) || w_fp_done || w_fp_tmo);
  assign w_push_res = (r_state == S_INT) ? i_alu_result :
                      (w_fp_done ? i_fpu_result : '0);

  assign o_out_valid  = (r_count != '0);
  assign w_pop        = o_out_valid && i_out_ready;
  assign o_out_result = o_out_valid ? r_mem_res[r_rd_ptr] : '0;
  assign o_out_tag    = o_out_valid ? r_mem_tag[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tag       <= '0;
      o_alu_op    <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_fpu_op    <= '0;
      o_fpu_a     <= '0;
      o_fpu_b     <= '0;
      o_fpu_start <= 1'b0;
      o_fpu_abort <= 1'b0;
`ifdef EXEC_FPU_WATCHDOG_EN
      r_wd_cnt    <= '0;
`endif
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        r_mem_res[i] <= '0;
        r_mem_tag[i] <= '0;
`ifdef EXEC_FPU_WATCHDOG_EN
        r_mem_err[i] <= 1'b0;
`endif
      end
    end else begin
      o_fpu_start <= 1'b0;
      o_fpu_abort <= 1'b0;
      if (i_flush) begin
        r_state     <= S_IDLE;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        o_fpu_abort <= (r_state == S_FP);
      end else begin
        if (w_push) begin
          r_mem_res[r_wr_ptr] <= w_push_res;
          r_mem_tag[r_wr_ptr] <= r_tag;
`ifdef EXEC_FPU_WATCHDOG_EN
          r_mem_err[r_wr_ptr] <= w_fp_tmo;
`endif
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);

        // Accept is only possible outside FP, so it never races FP completion.
        if (w_accept) begin
          r_tag <= i_in_tag;
          if (w_int_path) begin
            r_state  <= S_INT;
            o_alu_op <= i_in_aluop;
            o_alu_a  <= i_in_op1;
            o_alu_b  <= i_in_op2;
          end else begin
            r_state     <= S_FP;
            o_fpu_op    <= i_in_aluop;
            o_fpu_a     <= i_in_op1;
            o_fpu_b     <= i_in_op2;
            o_fpu_start <= 1'b1;
`ifdef EXEC_FPU_WATCHDOG_EN
            r_wd_cnt    <= '0;
`endif
          end
        end else if ((r_state != S_FP) || w_fp_done || w_fp_tmo) begin
          r_state <= S_IDLE;
        end

`ifdef EXEC_FPU_WATCHDOG_EN
        if ((r_state == S_FP) && !i_fpu_valid) r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (w_fp_tmo) o_fpu_abort <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (OUT_DEPTH=2, FPU_TIMEOUT=8).
module tb_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_fp;
  logic        in_mem;
  logic [3:0]  in_aluop;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [63:0] in_tag;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        fpu_valid;
  logic        fpu_abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [63:0] out_tag;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  exec_sequencer #(
    .DATA_WIDTH (32),
    .TAG_WIDTH  (64),
    .OUT_DEPTH  (2),
    .FPU_TIMEOUT(8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_fp     (in_fp),
    .i_in_mem    (in_mem),
    .i_in_aluop  (in_aluop),
    .i_in_op1    (in_op1),
    .i_in_op2    (in_op2),
    .i_in_tag    (in_tag),
    .o_alu_op    (alu_op),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .i_alu_result(alu_result),
    .o_fpu_start (fpu_start),
    .o_fpu_op    (fpu_op),
    .o_fpu_a     (fpu_a),
    .o_fpu_b     (fpu_b),
    .i_fpu_result(fpu_result),
    .i_fpu_valid (fpu_valid),
    .o_fpu_abort (fpu_abort),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_result(out_result),
    .o_out_tag   (out_tag),
    .o_out_err   (out_err)
  );

  // Combinational ALU stand-in
  assign alu_result = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fp, input logic mem, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] t);
    in_valid = v;
    in_fp    = fp;
    in_mem   = mem;
    in_aluop = op;
    in_op1   = a;
    in_op2   = b;
    in_tag   = t;
  endtask

  // A push must never land on a full FIFO
  always @(negedge clk) begin
    if (rst_n && dut.w_push)
      chk("push_when_full", 64'(dut.r_count == 2'd2), 64'd0);
  end

  logic [7:0] exp_rdy;
  logic [7:0] exp_vld;
  int         exp_res [8];
  int         exp_tag [8];
  int         p;

  initial begin
    exp_rdy = 8'b1101_1011;
    exp_vld = 8'b0110_1100;
    exp_res = '{0, 0, 7, 11, 0, 15, 19, 0};
    exp_tag = '{0, 0, 'h100, 'h101, 0, 'h102, 'h103, 0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fpu_valid = 1'b0; fpu_result = '0;
    drive(1'b1, 1'b0, 1'b0, 4'h1, 32'h11, 32'h22, 64'hdead);
    tick; tick; tick;
    chk("rst_in_ready",   64'(in_ready), 64'd0);
    chk("rst_out_valid",  64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag",    out_tag, 64'd0);
    chk("rst_out_err",    64'(out_err), 64'd0);
    chk("rst_fpu_start",  64'(fpu_start), 64'd0);
    chk("rst_fpu_abort",  64'(fpu_abort), 64'd0);
    chk("rst_alu_a",      64'(alu_a), 64'd0);
    chk("rst_alu_op",     64'(alu_op), 64'd0);
    chk("rst_fpu_b",      64'(fpu_b), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back integer stream with the sink always ready
    out_ready = 1'b1;
    p = 0;
    for (int c = 0; c < 8; c++) begin
      if (p < 4) drive(1'b1, 1'b0, 1'b0, 4'h0, 32'(3 + 2 * p), 32'(4 + 2 * p), 64'('h100 + p));
      else       in_valid = 1'b0;
      #1;
      chk($sformatf("b2b_ready_c%0d", c),  64'(in_ready),   64'(exp_rdy[c]));
      chk($sformatf("b2b_valid_c%0d", c),  64'(out_valid),  64'(exp_vld[c]));
      chk($sformatf("b2b_result_c%0d", c), 64'(out_result), 64'(exp_res[c]));
      chk($sformatf("b2b_tag_c%0d", c),    out_tag,         64'(exp_tag[c]));
      if (in_valid && exp_rdy[c]) p++;
      tick;
    end

    // Backpressure; first op has in_fp=1 with in_mem=1 and must use the ALU
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'h0, 32'd20, 32'd1, 64'h200);
    #1; chk("bp_ready0", 64'(in_ready), 64'd1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd30, 32'd2, 64'h201);
    #1; chk("bp_ready1", 64'(in_ready), 64'd1);
    chk("bp_mem_no_fpu_start", 64'(fpu_start), 64'd0);
    tick;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd40, 32'd3, 64'h202);
    #1; chk("bp_ready2", 64'(in_ready), 64'd0);
    tick;
    chk("bp_ready3", 64'(in_ready), 64'd0);
    chk("bp_head_result", 64'(out_result), 64'd21);
    chk("bp_head_tag", out_tag, 64'h200);
    tick;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1; chk("bp_ready_pop_cycle", 64'(in_ready), 64'd0);
    chk("bp_pop1_result", 64'(out_result), 64'd21);
    tick;
    chk("bp_pop2_result", 64'(out_result), 64'd32);
    chk("bp_pop2_tag", out_tag, 64'h201);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick;
    chk("bp_empty", 64'(out_valid), 64'd0);

    // FP op with latency 5
    drive(1'b1, 1'b1, 1'b0, 4'h3, 32'h3fc00000, 32'h3fc00000, 64'hA5);
    #1; chk("fp_accept_ready", 64'(in_ready), 64'd1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd1, 32'd1, 64'h999);
    #1;
    chk("fp_start_n1", 64'(fpu_start), 64'd1);
    chk("fp_op", 64'(fpu_op), 64'd3);
    chk("fp_a", 64'(fpu_a), 64'h3fc00000);
    chk("fp_ready_blocked", 64'(in_ready), 64'd0);
    tick;
    in_valid = 1'b0;
    chk("fp_start_one_cycle", 64'(fpu_start), 64'd0);
    chk("fp_ready_blocked2", 64'(in_ready), 64'd0);
    tick; tick;
    chk("fp_no_out_n4", 64'(out_valid), 64'd0);
    tick;
    fpu_valid = 1'b1;
    fpu_result = 32'h40400000;
    #1; chk("fp_no_out_n5", 64'(out_valid), 64'd0);
    tick;
    fpu_valid = 1'b0;
    chk("fp_out_valid_n6", 64'(out_valid), 64'd1);
    chk("fp_out_result", 64'(out_result), 64'h40400000);
    chk("fp_out_tag", out_tag, 64'hA5);
    chk("fp_out_err", 64'(out_err), 64'd0);
    tick;

    // FPU completing in its start cycle
    drive(1'b1, 1'b1, 1'b0, 4'h2, 32'h1, 32'h2, 64'hB6);
    tick;
    in_valid = 1'b0;
    fpu_valid = 1'b1;
    fpu_result = 32'h3f800000;
    #1; chk("fp0_start", 64'(fpu_start), 64'd1);
    tick;
    fpu_valid = 1'b0;
    chk("fp0_out_result", 64'(out_result), 64'h3f800000);
    chk("fp0_out_tag", out_tag, 64'hB6);
    chk("fp0_ready", 64'(in_ready), 64'd1);
    tick;
    chk("fp0_drained", 64'(out_valid), 64'd0);

    // Flush during FP with one result queued
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd5, 32'd5, 64'h300);
    tick;
    drive(1'b1, 1'b1, 1'b0, 4'h1, 32'h7, 32'h8, 64'h301);
    #1; chk("fl_fp_ready", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    chk("fl_fpu_start", 64'(fpu_start), 64'd1);
    chk("fl_queued_result", 64'(out_result), 64'd10);
    chk("fl_queued_tag", out_tag, 64'h300);
    tick;
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd9, 32'd9, 64'h302);
    #1; chk("fl_ready_during_flush", 64'(in_ready), 64'd0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_fifo_empty", 64'(out_valid), 64'd0);
    chk("fl_abort_pulse", 64'(fpu_abort), 64'd1);
    chk("fl_ready_after", 64'(in_ready), 64'd1);
    tick;
    fpu_valid = 1'b1;
    fpu_result = 32'hdeadbeef;
    #1; chk("fl_abort_one_cycle", 64'(fpu_abort), 64'd0);
    tick;
    fpu_valid = 1'b0;
    chk("fl_stale_valid_ignored", 64'(out_valid), 64'd0);
    chk("fl_stale_result", 64'(out_result), 64'd0);

`ifdef EXEC_FPU_WATCHDOG_EN
    // Watchdog expiry with FPU_TIMEOUT=8
    drive(1'b1, 1'b1, 1'b0, 4'h4, 32'h1, 32'h1, 64'h77);
    tick;
    in_valid = 1'b0;
    chk("wd_start", 64'(fpu_start), 64'd1);
    tick;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_wait_valid_%0d", k), 64'(out_valid), 64'd0);
      chk($sformatf("wd_wait_abort_%0d", k), 64'(fpu_abort), 64'd0);
      tick;
    end
    chk("wd_out_valid", 64'(out_valid), 64'd1);
    chk("wd_out_err", 64'(out_err), 64'd1);
    chk("wd_out_result", 64'(out_result), 64'd0);
    chk("wd_out_tag", out_tag, 64'h77);
    chk("wd_abort", 64'(fpu_abort), 64'd1);
    out_ready = 1'b1;
    tick;
    chk("wd_abort_once", 64'(fpu_abort), 64'd0);
    chk("wd_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
`endif

    // Reset while an FP op is outstanding aborts silently
    drive(1'b1, 1'b1, 1'b0, 4'h5, 32'h2, 32'h3, 64'h88);
    tick;
    in_valid = 1'b0;
    chk("rfp_start", 64'(fpu_start), 64'd1);
    rst_n = 1'b0;
    tick;
    chk("rfp_no_abort", 64'(fpu_abort), 64'd0);
    chk("rfp_start_clear", 64'(fpu_start), 64'd0);
    chk("rfp_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("rfp_idle_ready", 64'(in_ready), 64'd1);
    chk("rfp_still_no_abort", 64'(fpu_abort), 64'd0);
    chk("rfp_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
